pic_ack_sequencer: RTL
======================

// Module: pic_ack_sequencer
// PURPOSE
//  Clocked 8259-style interrupt core.
//  - Latches IR requests into the IRR and applies the IMR.
//  - Resolves priority (fixed or rotating) against the ISR.
//  - Raises INT and sequences the two-pulse INTA acknowledge.
//  - Handles EOI and auto-EOI.
//  Sits between the IR pins and the CPU bus interface; the command decoder drives its config and EOI inputs.
// PARAMETERS
//  SYNC_STAGES  2  flops in the INTA_N synchronizer (min 2)
//  VEC_BASE_W   5  width of the vector base (upper VECTOR bits); VECTOR = {VEC_BASE, level[2:0]}
// PORTS
//  CLK           in   1   system clock, all state on rising edge
//  RST           in   1   asynchronous, active-high reset
//  IR            in   8   raw interrupt request lines, IR0..IR7
//  IMR           in   8   mask register, 1 = masked
//  LTIM          in   1   1 = level-triggered, 0 = edge-triggered
//  AEOI          in   1   1 = auto-EOI on end of second INTA
//  ROTATE        in   1   1 = rotate priority on non-specific EOI
//  VEC_BASE      in   VEC_BASE_W  vector base
//  INTA_N        in   1   CPU acknowledge, active low, asynchronous
//  EOI_VALID     in   1   one-cycle EOI command strobe
//  EOI_SPECIFIC  in   1   1 = clear EOI_LEVEL, 0 = clear highest-priority ISR bit
//  EOI_LEVEL     in   3   level for a specific EOI
//  INT           out  1   interrupt request to the CPU
//  VECTOR        out  8   vector byte, valid while VECTOR_OE = 1
//  VECTOR_OE     out  1   drive enable for the data bus
//  IRR           out  8   interrupt request register
//  ISR           out  8   in-service register
// BEHAVIOUR
//  Reset values: INT, VECTOR_OE, VECTOR, IRR and ISR = 0; state = IDLE; LOWEST = 7, giving IR0 highest priority.
//  Priority order: the highest-priority level is LOWEST+1 mod 8, wrapping upward.
//  INTA synchronization:
//  - INTA_N passes through SYNC_STAGES flops.
//  - ack_fall / ack_rise are one-cycle pulses on edges of the synchronized signal.
//  IRR:
//  - Edge mode: a bit is set on a 0->1 of the registered IR, one cycle after IR is sampled. It is cleared only by the first ack of its level.
//  - Level mode: IRR = IR registered.
//  - Set and clear of the same bit in one cycle: set wins, so no request is lost.
//  - IMR does not block IRR latching.
//  Resolution:
//  - req = highest-priority set bit of IRR & ~IMR.
//  - svc = highest-priority set bit of ISR.
//  - INT (registered) = 1 in IDLE when req exists and is strictly higher than svc, or ISR = 0.
//  FSM states: IDLE -> ACK1 -> ACK2 -> IDLE.
//  - IDLE, ack_fall:
//    - Freeze lvl = req and set ISR[lvl].
//    - Clear IRR[lvl] in edge mode.
//    - Drop INT and go to ACK1.
//    - If no req exists at that instant, lvl = 7 and the cycle is spurious: ISR is not touched.
//  - ACK1, ack_rise: go to WAIT2, an internal sub-state of ACK1.
//  - WAIT2, ack_fall:
//    - Drive VECTOR = {VEC_BASE, lvl} and VECTOR_OE = 1, then go to ACK2.
//  - ACK2, ack_rise:
//    - Clear VECTOR_OE; VECTOR holds its value.
//    - If AEOI and not spurious, clear ISR[lvl].
//    - If AEOI and ROTATE, set LOWEST = lvl.
//    - Return to IDLE.
//  - INT stays 0 from the first ack until IDLE re-evaluates, 1 cycle later.
//  - IMR and IRR changes after the first ack do not alter lvl.
//  EOI (any state, applied in the strobe cycle):
//  - Specific: clear ISR[EOI_LEVEL].
//  - Non-specific: clear ISR[svc]; no-op if ISR = 0.
//  - If ROTATE and non-specific with ISR != 0, set LOWEST = svc.
//  - Same cycle as an ISR set from the first ack: the set wins for lvl; the EOI clear uses the pre-update ISR.
//  Boundaries:
//  - Several simultaneous requests: highest priority wins; the others remain in IRR.
//  - Nested interrupt: a higher-level req while ISR is busy re-raises INT.
//  - An equal or lower level is held off.
//  - RST mid-sequence returns everything to reset values immediately and drops VECTOR_OE.
// STRUCTURE
//  Package pic_pkg contains:
//  - state enum {IDLE, ACK1, WAIT2, ACK2}
//  - NUM_IR = 8 and SPURIOUS_LVL = 3'd7
//  - function rot_first(vec, lowest) returning {found, level[2:0]}
//  Sub-module pic_rot_prio_enc: rotating find-first. It is instanced twice, for the IRR&~IMR path and the ISR path.
//  All registers sit in the top-level module; the synchronizer is inline.
// TESTING
//  1. Edge request: IR3 pulses 0->1, IMR = 0, VEC_BASE = 5'h08.
//     -> INT = 1; two INTA_N pulses.
//     -> ISR = 8'h08 and IRR = 0 after the first pulse; VECTOR = 8'h43 with VECTOR_OE during the second pulse; INT = 0.
//  2. Simultaneous requests: IR5 and IR1 rise in the same cycle.
//     -> The first sequence serves level 1 (VECTOR low bits = 1); IRR = 8'h20 remains.
//     -> After a non-specific EOI, INT reasserts for level 5.
//  3. Rotation: ROTATE = 1; serve IR2, then a non-specific EOI.
//     -> LOWEST = 2; IR2 and IR3 then raised together -> level 3 is served first.
//  4. Masking and nesting:
//     -> IMR = 8'h10 with IR4 high -> INT stays 0, IRR[4] = 1.
//     -> While ISR = 8'h20, IR6 -> INT stays 0; IR0 -> INT = 1.
//  5. Spurious cycle: IR2 is withdrawn in level mode before the first INTA.
//     -> VECTOR low bits = 7, ISR unchanged. With AEOI = 1 there is no ISR clear.
//  6. Reset mid-ack: assert RST while VECTOR_OE = 1.
//     -> All outputs 0 asynchronously; the next INTA_N pulses are ignored until INT is raised again.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared constants and the rotating find-first helper for the PIC acknowledge core.
package pic_pkg;

  localparam int unsigned NUM_IR       = 8;
  localparam logic [2:0]  SPURIOUS_LVL = 3'd7;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACK1  = 2'd1;
  localparam logic [1:0] WAIT2 = 2'd2;
  localparam logic [1:0] ACK2  = 2'd3;

  // Returns {found, level}. Priority starts at lowest+1 and wraps upward.
  function automatic logic [3:0] rot_first(input logic [7:0] vec, input logic [2:0] lowest);
    logic [3:0] res;
    logic [2:0] idx;
    res = {1'b0, SPURIOUS_LVL};
    // Scan from lowest priority up so the highest-priority hit is written last.
    for (int i = 8; i >= 1; i--) begin
      idx = lowest + 3'(i);
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/pic_rot_prio_enc.sv
// Rotating priority find-first over eight request bits.
module pic_rot_prio_enc
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec,
  input  logic [2:0]        lowest,
  output logic              found,
  output logic [2:0]        level
);

  assign {found, level} = rot_first(vec, lowest);

endmodule

// File: rtl/pic_ack_sequencer.sv
// 8259-style interrupt core: IRR/ISR bookkeeping, priority resolution and
// the two-pulse INTA acknowledge sequence.
module pic_ack_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned VEC_BASE_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IR-1:0]     ir,
  input  logic [NUM_IR-1:0]     imr,
  input  logic                  ltim,
  input  logic                  aeoi,
  input  logic                  rotate,
  input  logic [VEC_BASE_W-1:0] vec_base,
  input  logic                  inta_n,
  input  logic                  eoi_valid,
  input  logic                  eoi_specific,
  input  logic [2:0]            eoi_level,
  output logic                  intr,
  output logic [VEC_BASE_W+2:0] vector,
  output logic                  vector_oe,
  output logic [NUM_IR-1:0]     irr,
  output logic [NUM_IR-1:0]     isr
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   inta_prev_q;
  logic                   inta_s, ack_fall, ack_rise;

  logic [NUM_IR-1:0]     ir_q, ir_prev_q;
  logic [NUM_IR-1:0]     irr_q, irr_d, irr_clr;
  logic [NUM_IR-1:0]     isr_q, isr_d;
  logic [2:0]            lowest_q, lowest_d;
  logic [1:0]            state_q, state_d;
  logic [2:0]            lvl_q, lvl_d;
  logic                  spur_q, spur_d;
  logic                  armed_q, armed_d;
  logic                  int_q, int_d;
  logic [VEC_BASE_W+2:0] vector_q, vector_d;
  logic                  oe_q, oe_d;

  logic       req_found, svc_found, int_cond, accept;
  logic [2:0] req_lvl, svc_lvl, req_rank, svc_rank;

  assign inta_s   = sync_q[SYNC_STAGES-1];
  assign ack_fall = inta_prev_q & ~inta_s;
  assign ack_rise = ~inta_prev_q & inta_s;

  pic_rot_prio_enc u_req_enc (
    .vec    (irr_q & ~imr),
    .lowest (lowest_q),
    .found  (req_found),
    .level  (req_lvl)
  );

  pic_rot_prio_enc u_svc_enc (
    .vec    (isr_q),
    .lowest (lowest_q),
    .found  (svc_found),
    .level  (svc_lvl)
  );

  // Rank 0 is the highest priority under the current rotation.
  assign req_rank = req_lvl - lowest_q - 3'd1;
  assign svc_rank = svc_lvl - lowest_q - 3'd1;
  assign int_cond = req_found && (!svc_found || (req_rank < svc_rank));

  // An ack is only taken once INT has been offered since the last sequence, so stray
  // INTA pulses after reset are ignored while a withdrawn request still ends as spurious.
  assign accept = (state_q == IDLE) && ack_fall && (armed_q || int_q);

  always_comb begin
    isr_d    = isr_q;
    lowest_d = lowest_q;
    state_d  = state_q;
    lvl_d    = lvl_q;
    spur_d   = spur_q;
    armed_d  = armed_q;
    int_d    = 1'b0;
    vector_d = vector_q;
    oe_d     = oe_q;
    irr_clr  = '0;

    // EOI clears act on the pre-update ISR; the ack set below overrides them.
    if (eoi_valid) begin
      if (eoi_specific) begin
        isr_d[eoi_level] = 1'b0;
      end else if (svc_found) begin
        isr_d[svc_lvl] = 1'b0;
        if (rotate) lowest_d = svc_lvl;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          lvl_d   = req_found ? req_lvl : SPURIOUS_LVL;
          spur_d  = !req_found;
          armed_d = 1'b0;
          state_d = ACK1;
          if (req_found) begin
            isr_d[req_lvl] = 1'b1;
            if (!ltim) irr_clr[req_lvl] = 1'b1;
          end
        end else begin
          int_d   = int_cond;
          armed_d = armed_q | int_q;
        end
      end
      ACK1: begin
        if (ack_rise) state_d = WAIT2;
      end
      WAIT2: begin
        if (ack_fall) begin
          vector_d = {vec_base, lvl_q};
          oe_d     = 1'b1;
          state_d  = ACK2;
        end
      end
      ACK2: begin
        if (ack_rise) begin
          oe_d    = 1'b0;
          state_d = IDLE;
          if (aeoi && !spur_q) isr_d[lvl_q] = 1'b0;
          if (aeoi && rotate) lowest_d = lvl_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Edge set wins over the ack clear so a request arriving in the ack cycle is kept.
    if (ltim) irr_d = ir;
    else      irr_d = (irr_q & ~irr_clr) | (ir_q & ~ir_prev_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '1;
      inta_prev_q <= 1'b1;
      ir_q        <= '0;
      ir_prev_q   <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      lowest_q    <= 3'd7;
      state_q     <= IDLE;
      lvl_q       <= SPURIOUS_LVL;
      spur_q      <= 1'b0;
      armed_q     <= 1'b0;
      int_q       <= 1'b0;
      vector_q    <= '0;
      oe_q        <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], inta_n};
      inta_prev_q <= inta_s;
      ir_q        <= ir;
      ir_prev_q   <= ir_q;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      lowest_q    <= lowest_d;
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      spur_q      <= spur_d;
      armed_q     <= armed_d;
      int_q       <= int_d;
      vector_q    <= vector_d;
      oe_q        <= oe_d;
    end
  end

  assign intr      = int_q;
  assign vector    = vector_q;
  assign vector_oe = oe_q;
  assign irr       = irr_q;
  assign isr       = isr_q;

endmodule
